// File: rtl/bf_pkg.sv
// Shared types for the beam-weight scheduler: weight word, cos/sin pair, FSM states.
// Types only; there is no logic, latency or flow control here.
// Imported by bf_weight_ram and bf_weight_sched.
package bf_pkg;

    localparam int NUM_CH = 8;
    localparam int W_W    = 5;

    typedef logic [W_W-1:0] weight_t;

    typedef struct packed {
        weight_t cos;
        weight_t sin;
    } wpair_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        DWELL
    } wsched_state_t;

endpackage

// File: rtl/bf_weight_ram.sv
// Beam weight table: NUM_BEAMS x 2 sources x NUM_CH cos/sin pairs held in flops.
// Latency: the scan read port is combinational; optional readback (BF_WSCHED_READBACK_EN) is 1 cycle.
// Backpressure: none; writes are gated by the scheduler and a same-cycle read returns the old entry.
module bf_weight_ram
    import bf_pkg::*;
#(
    parameter int NUM_BEAMS = 4,
    parameter int BEAM_W    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [BEAM_W-1:0] wr_beam,
    input  logic              wr_src,
    input  logic [2:0]        wr_ch,
    input  wpair_t            wr_dat,
    input  logic [BEAM_W-1:0] scan_beam,
    input  logic [2:0]        scan_ch,
    output wpair_t            scan_dat_1,
    output wpair_t            scan_dat_2
`ifdef BF_WSCHED_READBACK_EN
    ,
    input  logic              rd_req,
    input  logic [BEAM_W-1:0] rd_beam,
    input  logic              rd_src,
    input  logic [2:0]        rd_ch,
    output weight_t           rd_cos,
    output weight_t           rd_sin,
    output logic              rd_vld
`endif
);

    wpair_t mem [NUM_BEAMS][2][NUM_CH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BEAMS; b++) begin
                for (int s = 0; s < 2; s++) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        mem[b][s][c] <= '0;
                    end
                end
            end
        end else if (wr_en) begin
            mem[wr_beam][wr_src][wr_ch] <= wr_dat;
        end
    end

    assign scan_dat_1 = mem[scan_beam][0][scan_ch];
    assign scan_dat_2 = mem[scan_beam][1][scan_ch];

`ifdef BF_WSCHED_READBACK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_vld <= 1'b0;
            rd_cos <= '0;
            rd_sin <= '0;
        end else begin
            rd_vld <= rd_req;
            if (rd_req) begin
                rd_cos <= mem[rd_beam][rd_src][rd_ch].cos;
                rd_sin <= mem[rd_beam][rd_src][rd_ch].sin;
            end
        end
    end
`endif

endmodule

// File: rtl/bf_weight_sched.sv
// Beam-weight scheduler: loads each beam into shadow, commits it on lo_sync, dwells, advances. Option: BF_WSCHED_READBACK_EN.
// Latency: start -> first commit is 9 cycles plus up to 3 cycles of lo_sync alignment; commit is a registered pulse.
// Backpressure: wr_ready drops only while the beam being loaded is the write target; the write waits, never drops.
module bf_weight_sched
    import bf_pkg::*;
#(
    parameter int NUM_BEAMS = 4,
    parameter int DWELL_W   = 16,
    parameter int BEAM_W    = (NUM_BEAMS > 1) ? $clog2(NUM_BEAMS) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       lo_sync,
    input  logic                       start,
    input  logic                       stop,
    input  logic [BEAM_W-1:0]          last_beam,
    input  logic [DWELL_W-1:0]         dwell_len,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [BEAM_W-1:0]          wr_beam,
    input  logic                       wr_src,
    input  logic [2:0]                 wr_ch,
    input  weight_t                    wr_cos,
    input  weight_t                    wr_sin,
    output weight_t [NUM_CH-1:0]       w_cos_1,
    output weight_t [NUM_CH-1:0]       w_sin_1,
    output weight_t [NUM_CH-1:0]       w_cos_2,
    output weight_t [NUM_CH-1:0]       w_sin_2,
    output logic [BEAM_W-1:0]          beam_idx,
    output logic                       commit,
    output logic                       busy
`ifdef BF_WSCHED_READBACK_EN
    ,
    input  logic                       rd_req,
    input  logic [BEAM_W-1:0]          rd_beam,
    input  logic                       rd_src,
    input  logic [2:0]                 rd_ch,
    output weight_t                    rd_cos,
    output weight_t                    rd_sin,
    output logic                       rd_vld
`endif
);

    localparam logic [BEAM_W:0]   BEAM_LIMIT = (BEAM_W+1)'(NUM_BEAMS);
    localparam logic [BEAM_W-1:0] BEAM_MAX   = BEAM_W'(NUM_BEAMS - 1);

    wsched_state_t      state;
    wsched_state_t      state_nxt;
    logic [BEAM_W-1:0]  cur;
    logic [BEAM_W-1:0]  last_q;
    logic [BEAM_W-1:0]  last_clamped;
    logic [2:0]         ld_ch;
    logic [DWELL_W-1:0] dwell_cnt;
    wpair_t             shadow [2][NUM_CH];
    wpair_t             scan_dat_1;
    wpair_t             scan_dat_2;
    logic               do_start;
    logic               load_en;
    logic               do_commit;
    logic               do_advance;

    assign last_clamped = ({1'b0, last_beam} >= BEAM_LIMIT) ? BEAM_MAX : last_beam;
    assign wr_ready     = !((state == LOAD) && (wr_beam == cur));
    assign busy         = (state != IDLE);

    bf_weight_ram #(
        .NUM_BEAMS (NUM_BEAMS),
        .BEAM_W    (BEAM_W)
    ) u_ram (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_valid && wr_ready),
        .wr_beam    (wr_beam),
        .wr_src     (wr_src),
        .wr_ch      (wr_ch),
        .wr_dat     ({wr_cos, wr_sin}),
        .scan_beam  (cur),
        .scan_ch    (ld_ch),
        .scan_dat_1 (scan_dat_1),
        .scan_dat_2 (scan_dat_2)
`ifdef BF_WSCHED_READBACK_EN
        ,
        .rd_req     (rd_req),
        .rd_beam    (rd_beam),
        .rd_src     (rd_src),
        .rd_ch      (rd_ch),
        .rd_cos     (rd_cos),
        .rd_sin     (rd_sin),
        .rd_vld     (rd_vld)
`endif
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // stop has priority over every other transition, including a coincident lo_sync
    always_comb begin
        state_nxt  = state;
        do_start   = 1'b0;
        load_en    = 1'b0;
        do_commit  = 1'b0;
        do_advance = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    do_start  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else begin
                    load_en = 1'b1;
                    if (ld_ch == 3'd7) begin
                        state_nxt = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (lo_sync) begin
                    do_commit = 1'b1;
                    state_nxt = DWELL;
                end
            end
            DWELL: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (dwell_cnt == '0) begin
                    do_advance = 1'b1;
                    state_nxt  = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur       <= '0;
            last_q    <= '0;
            ld_ch     <= '0;
            dwell_cnt <= '0;
            w_cos_1   <= '0;
            w_sin_1   <= '0;
            w_cos_2   <= '0;
            w_sin_2   <= '0;
            beam_idx  <= '0;
            commit    <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    shadow[s][k] <= '0;
                end
            end
        end else begin
            commit <= do_commit;
            if (do_start) begin
                cur   <= '0;
                ld_ch <= '0;
            end
            if (load_en) begin
                shadow[0][ld_ch] <= scan_dat_1;
                shadow[1][ld_ch] <= scan_dat_2;
                ld_ch            <= ld_ch + 3'd1;
            end
            // dwell length and scan extent are frozen per beam at commit time
            if (do_commit) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    w_cos_1[k] <= shadow[0][k].cos;
                    w_sin_1[k] <= shadow[0][k].sin;
                    w_cos_2[k] <= shadow[1][k].cos;
                    w_sin_2[k] <= shadow[1][k].sin;
                end
                beam_idx  <= cur;
                last_q    <= last_clamped;
                dwell_cnt <= (dwell_len == '0) ? '0 : dwell_len - 1'b1;
            end else if ((state == DWELL) && (dwell_cnt != '0)) begin
                dwell_cnt <= dwell_cnt - 1'b1;
            end
            if (do_advance) begin
                cur   <= (cur >= last_q) ? '0 : cur + 1'b1;
                ld_ch <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bf_weight_sched.sv
// Scoreboard bench for bf_weight_sched: expected commits are queued at stimulus time and checked by a monitor.
// Covers reset, single-beam repeat, wrap, write collision, stop handling and (if enabled) readback.
module tb_bf_weight_sched;
    import bf_pkg::*;

    localparam int BW = 2;

    logic                 clock     = 1'b0;
    logic                 reset     = 1'b1;
    logic                 lo_sync   = 1'b0;
    logic                 start     = 1'b0;
    logic                 stop      = 1'b0;
    logic [BW-1:0]        last_beam = '0;
    logic [15:0]          dwell_len = '0;
    logic                 wr_valid  = 1'b0;
    logic                 wr_ready;
    logic [BW-1:0]        wr_beam   = '0;
    logic                 wr_src    = 1'b0;
    logic [2:0]           wr_ch     = '0;
    weight_t              wr_cos    = '0;
    weight_t              wr_sin    = '0;
    weight_t [NUM_CH-1:0] w_cos_1;
    weight_t [NUM_CH-1:0] w_sin_1;
    weight_t [NUM_CH-1:0] w_cos_2;
    weight_t [NUM_CH-1:0] w_sin_2;
    logic [BW-1:0]        beam_idx;
    logic                 commit;
    logic                 busy;
`ifdef BF_WSCHED_READBACK_EN
    logic                 rd_req  = 1'b0;
    logic [BW-1:0]        rd_beam = '0;
    logic                 rd_src  = 1'b0;
    logic [2:0]           rd_ch   = '0;
    weight_t              rd_cos;
    weight_t              rd_sin;
    logic                 rd_vld;
`endif

    bf_weight_sched #(
        .NUM_BEAMS (4),
        .DWELL_W   (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .lo_sync   (lo_sync),
        .start     (start),
        .stop      (stop),
        .last_beam (last_beam),
        .dwell_len (dwell_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_beam   (wr_beam),
        .wr_src    (wr_src),
        .wr_ch     (wr_ch),
        .wr_cos    (wr_cos),
        .wr_sin    (wr_sin),
        .w_cos_1   (w_cos_1),
        .w_sin_1   (w_sin_1),
        .w_cos_2   (w_cos_2),
        .w_sin_2   (w_sin_2),
        .beam_idx  (beam_idx),
        .commit    (commit),
        .busy      (busy)
`ifdef BF_WSCHED_READBACK_EN
        ,
        .rd_req    (rd_req),
        .rd_beam   (rd_beam),
        .rd_src    (rd_src),
        .rd_ch     (rd_ch),
        .rd_cos    (rd_cos),
        .rd_sin    (rd_sin),
        .rd_vld    (rd_vld)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int beam;
        int c1;
        int s1;
        int c2;
        int gmin;
        int gmax;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   ref_cyc = 0;
    int   lo_cnt  = 0;
    logic lo_edge = 1'b0;
    int   blocked;

    // beam table: src0 ch3 (cos, sin) and src1 ch5 cos for beams 0..2
    int c1_t[3] = '{15, 3, 21};
    int s1_t[3] = '{17, 28, 10};
    int c2_t[3] = '{1, 2, 30};

    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) lo_edge <= lo_sync;

    initial begin
        forever begin
            @(posedge clock);
            #1;
            lo_cnt  = (lo_cnt + 1) % 4;
            lo_sync = (lo_cnt == 3);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && commit) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: commit at cycle %0d with beam_idx %0d, expected no commit", cyc, beam_idx);
            end else begin
                mon_e = sb.pop_front();
                chk("beam_idx", int'(beam_idx), mon_e.beam);
                chk("w_cos_1[3]", int'(w_cos_1[3]), mon_e.c1);
                chk("w_sin_1[3]", int'(w_sin_1[3]), mon_e.s1);
                chk("w_cos_2[5]", int'(w_cos_2[5]), mon_e.c2);
                chk("commit_on_lo_sync", int'(lo_edge), 1);
                checks++;
                if ((cyc - ref_cyc) < mon_e.gmin || (cyc - ref_cyc) > mon_e.gmax) begin
                    errors++;
                    $display("FAIL commit_gap: got %0d cycles, expected %0d..%0d", cyc - ref_cyc, mon_e.gmin, mon_e.gmax);
                end
            end
            ref_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int b, input int s, input int c, input int cw, input int sw, output int nblk);
        wr_valid = 1'b1;
        wr_beam  = BW'(b);
        wr_src   = 1'(s);
        wr_ch    = 3'(c);
        wr_cos   = weight_t'(cw);
        wr_sin   = weight_t'(sw);
        nblk     = 0;
        forever begin
            @(negedge clock);
            if (wr_ready) break;
            nblk++;
            if (nblk > 50) begin
                checks++;
                errors++;
                $display("FAIL wr_timeout: wr_ready low for %0d cycles, expected at most 8", nblk);
                break;
            end
        end
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic load_tables();
        for (int b = 0; b < 3; b++) begin
            wr(b, 0, 3, c1_t[b], s1_t[b], blocked);
            chk("wr_ready_idle", blocked, 0);
            wr(b, 1, 5, c2_t[b], 7, blocked);
        end
    endtask

    task automatic push(input int b, input int c1, input int s1, input int c2, input int gmin, input int gmax);
        exp_t e;
        e.beam = b;
        e.c1   = c1;
        e.s1   = s1;
        e.c2   = c2;
        e.gmin = gmin;
        e.gmax = gmax;
        sb.push_back(e);
    endtask

    task automatic start_scan(input int lb, input int dl);
        last_beam = BW'(lb);
        dwell_len = 16'(dl);
        start     = 1'b1;
        ref_cyc   = cyc + 1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_empty(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_w_cos_1[3]", int'(w_cos_1[3]), 0);
        chk("rst_beam_idx", int'(beam_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_commit", int'(commit), 0);
        chk("rst_wr_ready", int'(wr_ready), 1);
`ifdef BF_WSCHED_READBACK_EN
        chk("rst_rd_vld", int'(rd_vld), 0);
`endif
        reset = 1'b0;
        tick();

        // single beam repeated: first commit 9..12 after start, then every 16 cycles
        load_tables();
        push(0, 15, 17, 1, 9, 12);
        push(0, 15, 17, 1, 16, 16);
        push(0, 15, 17, 1, 16, 16);
        start_scan(0, 4);
        wait_empty(200);

        // asynchronous reset while dwelling
        chk("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("arst_w_cos_1[3]", int'(w_cos_1[3]), 0);
        chk("arst_w_sin_1[3]", int'(w_sin_1[3]), 0);
        chk("arst_beam_idx", int'(beam_idx), 0);
        chk("arst_busy", int'(busy), 0);
        tick();
        tick();
        reset = 1'b0;
        chk("post_rst_wr_ready", int'(wr_ready), 1);
        repeat (20) tick();

        // wrap 0,1,2,0 with one-cycle dwell
        load_tables();
        push(0, c1_t[0], s1_t[0], c2_t[0], 9, 12);
        push(1, c1_t[1], s1_t[1], c2_t[1], 12, 12);
        push(2, c1_t[2], s1_t[2], c2_t[2], 12, 12);
        push(0, c1_t[0], s1_t[0], c2_t[0], 12, 12);
        start_scan(2, 0);
        wait_empty(200);
        do_stop();
        chk("wrap_stop_busy", int'(busy), 0);

        // write to the beam being loaded stalls for all 8 LOAD cycles
        push(0, 15, 17, 1, 9, 12);
        push(1, 3, 28, 2, 12, 12);
        push(0, 26, 5, 1, 12, 12);
        start_scan(1, 2);
        wr(0, 0, 3, 26, 5, blocked);
        chk("wr_blocked_cycles", blocked, 8);
        wait_empty(200);
        do_stop();
        chk("coll_stop_busy", int'(busy), 0);

        // stop in the 4th LOAD cycle: no commit, outputs keep the last beam
        start_scan(1, 2);
        tick();
        tick();
        tick();
        do_stop();
        chk("load_stop_busy", int'(busy), 0);
        chk("load_stop_beam_idx", int'(beam_idx), 0);
        chk("load_stop_w_cos_1[3]", int'(w_cos_1[3]), 26);
        repeat (20) tick();
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        chk("stop_start_busy", int'(busy), 0);
        tick();
        chk("stop_start_busy_2", int'(busy), 0);

`ifdef BF_WSCHED_READBACK_EN
        wr(1, 1, 7, 31, 0, blocked);
        rd_req  = 1'b1;
        rd_beam = BW'(1);
        rd_src  = 1'b1;
        rd_ch   = 3'd7;
        tick();
        rd_req  = 1'b0;
        @(negedge clock);
        chk("rd_vld", int'(rd_vld), 1);
        chk("rd_cos", int'(rd_cos), 31);
        chk("rd_sin", int'(rd_sin), 0);
        tick();
        chk("rd_vld_clear", int'(rd_vld), 0);
`endif

        repeat (5) tick();
        chk("scoreboard_empty_at_end", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
